btn_pulser: RTL and testbench
=============================

BTN_PULSER -- requirements
Module: btn_pulser

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels, 1..32.
REQ-002 Parameter DEB_CYCLES, default 4: consecutive stable synchronised samples required to accept a level change, 2..65535.
REQ-003 Parameter MODE, default 0: pulse source; 0 = press, 1 = release, 2 = press and release.
REQ-004 Parameter REPEAT_EN, default 0: 1 enables auto-repeat pulses while a channel is held.
REQ-005 Parameter REPEAT_CYCLES, default 16: auto-repeat period in clocks, 2..65535.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 bi  input  N_CH  raw, asynchronous, bouncing button levels; 1 = pressed.
REQ-009 bo  output  N_CH  registered one-cycle pulse per channel.
REQ-010 level  output  N_CH  registered debounced level per channel.
REQ-011 any_bo  output  1  OR of all bo bits; no added register stage.

Function
REQ-012 Each bi bit SHALL pass through a 2-flop synchroniser; only the second flop output (s) drives channel logic.
REQ-013 Each channel SHALL run its own 4-state FSM: IDLE, DEB_HI, HELD, DEB_LO.
REQ-014 IDLE: s=1 -> DEB_HI with cnt=1; otherwise stay in IDLE.
REQ-015 DEB_HI: s=0 -> IDLE with cnt=0; s=1 and cnt=DEB_CYCLES-1 -> HELD; otherwise cnt+1.
REQ-016 HELD: s=0 -> DEB_LO with cnt=1; otherwise stay in HELD.
REQ-017 DEB_LO: s=1 -> HELD with cnt=0 and no pulse; s=0 and cnt=DEB_CYCLES-1 -> IDLE; otherwise cnt+1.
REQ-018 level SHALL be 1 exactly while the FSM is in HELD or DEB_LO.
REQ-019 Press pulse (MODE 0/2): bo high for exactly the first cycle in HELD entered from DEB_HI.
REQ-019a Press latency: DEB_CYCLES+2 rising edges, counting the edge that first samples bi=1 as edge 1.
REQ-020 Release pulse (MODE 1/2): bo high for exactly the first cycle in IDLE entered from DEB_LO.
REQ-021 Auto-repeat (REPEAT_EN=1, MODE 0/2): while in HELD, bo pulses once every REPEAT_CYCLES clocks, the first REPEAT_CYCLES clocks after the press pulse.
REQ-022 The repeat counter SHALL clear on leaving HELD; re-entry to HELD from DEB_LO restarts the full period.
REQ-023 Bounce shorter than DEB_CYCLES samples SHALL produce no pulse and no level change.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels pulse the same cycle with no arbitration.
REQ-025 Counter width SHALL be $clog2(max(DEB_CYCLES,REPEAT_CYCLES)+1) bits; counters SHALL never wrap.
REQ-026 MODE values other than 0..2 SHALL be rejected at elaboration.

Reset
REQ-027 rst=0 SHALL asynchronously force synchronisers to 0, FSMs to IDLE, counters to 0, and bo, level and any_bo to 0.
REQ-028 Reset assertion mid-debounce or mid-hold SHALL abort the operation with no pulse.
REQ-029 bi held at 1 across reset release SHALL be debounced normally and yield one press pulse.

Structure
REQ-030 The shared package btn_pkg SHALL hold the state enum and the MODE_PRESS, MODE_RELEASE and MODE_BOTH constants.
REQ-031 Per-channel logic (synchroniser, FSM, counters) SHALL live in sub-module btn_channel, instantiated N_CH times by a generate loop.

Verification
REQ-032 Press: N_CH=4, DEB_CYCLES=4, MODE=0; bi[0] 0->1 held -> bo[0] high for one cycle on edge 6, level[0] high from edge 6.
REQ-033 Bounce: bi[1] toggles high for 3 cycles, low for 1, then high for 3 -> bo[1] and level[1] stay 0.
REQ-034 Release and repeat: MODE=2, REPEAT_EN=1, REPEAT_CYCLES=8; hold bi[2] for 30 cycles, then release. Required: press pulse, repeat pulses 8 and 16 cycles later, and one release pulse DEB_CYCLES+2 edges after release.
REQ-035 Simultaneous: bi[3:0] rise on the same edge -> bo=4'hF for exactly one cycle and any_bo=1 in that cycle only.
REQ-036 Reset: assert rst=0 while in DEB_HI with cnt=2 -> outputs 0 immediately. Keep bi=1 through release -> one press pulse DEB_CYCLES+2 edges after release.

Source files
------------

// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared types and constants for the button pulser: per-channel
//                debounce FSM state encoding, pulse-source mode codes and the
//                counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    // Per-channel debounce FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEB_HI = 2'd1,
        HELD   = 2'd2,
        DEB_LO = 2'd3
    } btn_state_e;

    // Pulse source selection.
    localparam int MODE_PRESS   = 0;
    localparam int MODE_RELEASE = 1;
    localparam int MODE_BOTH    = 2;

    // Width that holds the larger terminal count so neither counter can wrap.
    function automatic int cnt_width(input int deb, input int rep);
        int m;
        m = (deb > rep) ? deb : rep;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ============================================================================
//  Module      : btn_channel
//  Description : One button channel: 2-flop synchroniser, 4-state debounce
//                FSM, optional auto-repeat and registered pulse/level outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES    = 4,
    parameter int MODE          = 0,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_bi,
    output logic o_bo,
    output logic o_level
);

    localparam int             CW         = cnt_width(DEB_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0]  C_ONE      = CW'(1);
    localparam logic [CW-1:0]  C_DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0]  C_REP_LAST = CW'(REPEAT_CYCLES - 1);
    localparam bit             C_PRESS_EN = (MODE == MODE_PRESS) || (MODE == MODE_BOTH);
    localparam bit             C_REL_EN   = (MODE == MODE_RELEASE) || (MODE == MODE_BOTH);
    // Auto-repeat only makes sense when press pulses are being generated.
    localparam bit             C_REP_EN   = (REPEAT_EN != 0) && C_PRESS_EN;

    logic          r_sync1;
    logic          r_sync2;
    btn_state_e    r_state;
    btn_state_e    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] r_rcnt;
    logic [CW-1:0] w_rcnt_nxt;
    logic          r_bo;
    logic          w_bo_nxt;
    logic          r_level;
    logic          w_level_nxt;

    // Two-flop synchroniser for the raw asynchronous button level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_bi;
            r_sync2 <= r_sync1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rcnt  <= '0;
            r_bo    <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rcnt  <= w_rcnt_nxt;
            r_bo    <= w_bo_nxt;
            r_level <= w_level_nxt;
        end
    end

    // Debounce transitions; the repeat counter defaults to zero so it clears
    // whenever the channel is not sitting in HELD.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rcnt_nxt  = '0;
        w_bo_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = DEB_HI;
                    w_cnt_nxt   = C_ONE;
                end
            end
            DEB_HI: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_DEB_LAST) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                    w_bo_nxt    = C_PRESS_EN;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            HELD: begin
                if (!r_sync2) begin
                    w_state_nxt = DEB_LO;
                    w_cnt_nxt   = C_ONE;
                end else if (C_REP_EN) begin
                    if (r_rcnt == C_REP_LAST) begin
                        w_bo_nxt = 1'b1;
                    end else begin
                        w_rcnt_nxt = r_rcnt + C_ONE;
                    end
                end
            end
            DEB_LO: begin
                if (r_sync2) begin
                    // Aborted release: back to HELD silently, repeat period restarts.
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_DEB_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_bo_nxt    = C_REL_EN;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_level_nxt = (w_state_nxt == HELD) || (w_state_nxt == DEB_LO);
    end

    assign o_bo    = r_bo;
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/btn_pulser.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pulser
//  Description : N_CH independent debounced button channels producing one-cycle
//                press/release/auto-repeat pulses plus debounced levels.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_pulser
    import btn_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int DEB_CYCLES    = 4,
    parameter int MODE          = 0,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] bi,
    output logic [N_CH-1:0] bo,
    output logic [N_CH-1:0] level,
    output logic            any_bo
);

    // Refuse to build with an undefined pulse source.
    if ((MODE < MODE_PRESS) || (MODE > MODE_BOTH)) begin : g_bad_mode
        $error("btn_pulser: MODE must be 0, 1 or 2");
    end

    // One fully independent channel per button.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_channel #(
            .DEB_CYCLES    (DEB_CYCLES),
            .MODE          (MODE),
            .REPEAT_EN     (REPEAT_EN),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_channel (
            .clk     (clk),
            .rst     (rst),
            .i_bi    (bi[i]),
            .o_bo    (bo[i]),
            .o_level (level[i])
        );
    end

    // Combinational OR of the already-registered pulses.
    assign any_bo = |bo;

endmodule
`default_nettype wire

// File: tb/tb_btn_pulser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_pulser
//  Description : Self-checking bench for btn_pulser with a run-length debounce
//                reference model, directed scenarios and random button traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_pulser;

    localparam int N_CH = 4;
    localparam int DEB  = 4;
    localparam int MODE = 2;
    localparam int REP  = 8;

    logic            clk;
    logic            rst;
    logic [N_CH-1:0] bi;
    logic [N_CH-1:0] bo;
    logic [N_CH-1:0] level;
    logic            any_bo;

    int n_cmp;
    int n_bad;
    int edge_n;
    int bo1_cnt;

    btn_pulser #(
        .N_CH          (N_CH),
        .DEB_CYCLES    (DEB),
        .MODE          (MODE),
        .REPEAT_EN     (1),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bi     (bi),
        .bo     (bo),
        .level  (level),
        .any_bo (any_bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Debounced level flips after DEB consecutive synchronised samples that
    // disagree with it; repeats fire every REP edges after entering HELD.
    logic [N_CH-1:0] m_s1;
    logic [N_CH-1:0] m_s2;
    logic [N_CH-1:0] m_lvl;
    int              m_run  [N_CH];
    int              m_tent [N_CH];
    int              m_cyc;
    logic [N_CH-1:0] e_bo;
    logic [N_CH-1:0] e_lvl;

    task automatic model_reset();
        m_s1  = '0;
        m_s2  = '0;
        m_lvl = '0;
        e_bo  = '0;
        e_lvl = '0;
        for (int c = 0; c < N_CH; c++) begin
            m_run[c]  = 0;
            m_tent[c] = 0;
        end
    endtask

    task automatic model_step();
        logic s;
        m_cyc++;
        for (int c = 0; c < N_CH; c++) begin
            s        = m_s2[c];
            m_s2[c]  = m_s1[c];
            m_s1[c]  = bi[c];
            e_bo[c]  = 1'b0;
            if (s != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == DEB) begin
                    m_lvl[c] = s;
                    m_run[c] = 0;
                    e_bo[c]  = 1'b1;   // both press and release pulse in MODE 2
                    if (s) m_tent[c] = m_cyc;
                end
            end else begin
                if (m_run[c] != 0 && m_lvl[c]) m_tent[c] = m_cyc;
                m_run[c] = 0;
                if (m_lvl[c] && m_tent[c] != m_cyc && ((m_cyc - m_tent[c]) % REP) == 0)
                    e_bo[c] = 1'b1;
            end
            e_lvl[c] = m_lvl[c];
        end
    endtask

    initial begin
        m_cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc_bo",     32'(bo),     32'(e_bo));
        chk("cyc_level",  32'(level),  32'(e_lvl));
        chk("cyc_any_bo", 32'(any_bo), 32'(|e_bo));
        if (bo[1] === 1'b1) bo1_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            edge_n++;
        end
    endtask

    task automatic step_to(input int e);
        while (edge_n < e) step(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int hold_left [N_CH];
        int b0;
        n_cmp   = 0;
        n_bad   = 0;
        edge_n  = 0;
        bo1_cnt = 0;
        bi      = '0;
        rst     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_bo",     32'(bo),     32'h0);
        chk("reset_level",  32'(level),  32'h0);
        chk("reset_any_bo", 32'(any_bo), 32'h0);
        #1 rst = 1'b1;
        step(2);

        // Press on channel 0: pulse on edge DEB+2 = 6.
        #1 bi = 4'b0001; edge_n = 0;
        step_to(5);
        chk("press_e5_bo",    32'(bo),    32'h0);
        chk("press_e5_level", 32'(level), 32'h0);
        step_to(6);
        chk("press_e6_bo",     32'(bo),     32'h1);
        chk("press_e6_level",  32'(level),  32'h1);
        chk("press_e6_any_bo", 32'(any_bo), 32'h1);
        step_to(7);
        chk("press_e7_bo",    32'(bo),    32'h0);
        chk("press_e7_level", 32'(level), 32'h1);
        #1 bi = '0;
        step(20);
        chk("press_idle_level", 32'(level), 32'h0);

        // Bounce on channel 1: 3 high, 1 low, 3 high never qualifies.
        b0 = bo1_cnt;
        #1 bi[1] = 1'b1; step(3);
        #1 bi[1] = 1'b0; step(1);
        #1 bi[1] = 1'b1; step(3);
        #1 bi[1] = 1'b0; step(12);
        chk("bounce_level",   32'(level),        32'h0);
        chk("bounce_pulses",  32'(bo1_cnt - b0), 32'h0);

        // Hold channel 2 for 30 edges: press at 6, repeats at 14/22/30,
        // release sampled on edge 31 pulses on edge 36.
        #1 bi[2] = 1'b1; edge_n = 0;
        step_to(6);  chk("rep_press_bo", 32'(bo), 32'h4);
        step_to(13); chk("rep_e13_bo",   32'(bo), 32'h0);
        step_to(14); chk("rep_e14_bo",   32'(bo), 32'h4);
        step_to(22); chk("rep_e22_bo",   32'(bo), 32'h4);
        step_to(30); chk("rep_e30_bo",   32'(bo), 32'h4);
        #1 bi[2] = 1'b0;
        step_to(35);
        chk("rel_e35_bo",    32'(bo),    32'h0);
        chk("rel_e35_level", 32'(level), 32'h4);
        step_to(36);
        chk("rel_e36_bo",    32'(bo),    32'h4);
        chk("rel_e36_level", 32'(level), 32'h0);
        step_to(37);
        chk("rel_e37_bo",    32'(bo),    32'h0);
        step(10);

        // All channels rise together.
        #1 bi = 4'hF; edge_n = 0;
        step_to(5); chk("simul_e5_any_bo", 32'(any_bo), 32'h0);
        step_to(6);
        chk("simul_e6_bo",     32'(bo),     32'hF);
        chk("simul_e6_any_bo", 32'(any_bo), 32'h1);
        step_to(7);
        chk("simul_e7_bo",     32'(bo),     32'h0);
        chk("simul_e7_any_bo", 32'(any_bo), 32'h0);
        #1 bi = '0;
        step(20);

        // Reset while channel 1 is held and channel 0 is mid-debounce.
        #1 bi = 4'b0010;
        step(8);
        chk("rst_pre_level", 32'(level), 32'h2);
        #1 bi = 4'b0011; edge_n = 0;
        step_to(4);
        #1 rst = 1'b0;
        #1;
        chk("rst_async_level", 32'(level),  32'h0);
        chk("rst_async_bo",    32'(bo),     32'h0);
        chk("rst_async_any",   32'(any_bo), 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1; edge_n = 0;
        step_to(5); chk("rst_rel_e5_bo", 32'(bo), 32'h0);
        step_to(6);
        chk("rst_rel_e6_bo",    32'(bo),    32'h3);
        chk("rst_rel_e6_level", 32'(level), 32'h3);
        step_to(7); chk("rst_rel_e7_bo", 32'(bo), 32'h0);
        #1 bi = '0;
        step(20);

        // Random traffic: mixed short bounces and long holds, rare async resets.
        for (int c = 0; c < N_CH; c++) hold_left[c] = $urandom_range(0, 5);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            #1;
            for (int c = 0; c < N_CH; c++) begin
                if (hold_left[c] == 0) begin
                    bi[c] = ~bi[c];
                    if ($urandom_range(0, 2) == 0) hold_left[c] = $urandom_range(0, 3);
                    else                           hold_left[c] = $urandom_range(4, 40);
                end else begin
                    hold_left[c]--;
                end
            end
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b0;
                #2 rst = 1'b1;
            end
        end
        #1 bi = '0;
        step(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
